// File: rtl/adld_sqrt_arb.sv
// adld_sqrt_arb: round-robin arbiter sharing one square-root core among NREQ requesters
module adld_sqrt_arb #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 64,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_rad,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      res_root,
  output logic [WIDTH-1:0]      res_rem,
  output logic [IW-1:0]         res_id,
  output logic                  err,
  output logic                  sq_start,
  output logic [WIDTH-1:0]      sq_rad,
  input  logic                  sq_busy,
  input  logic                  sq_valid,
  input  logic [WIDTH-1:0]      sq_root,
  input  logic [WIDTH-1:0]      sq_rem
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [IW-1:0] last_grant, cur_id, win;
  logic [TW-1:0] timer;
  logic found;
  int k;
  // search starts just past the previous winner so every requester gets a turn
  always_comb begin
    win = '0;
    found = 1'b0;
    k = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = int'(last_grant) + i;
      k = (k >= NREQ) ? k - NREQ : k;
      if (!found && req[IW'(k)]) begin
        found = 1'b1;
        win = IW'(k);
      end
    end
  end
  assign sq_start = state == ISSUE;
  assign ack = (state == DONE) ? {{(NREQ-1){1'b0}}, 1'b1} << res_id : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sq_rad <= '0;
      res_root <= '0;
      res_rem <= '0;
      res_id <= '0;
      err <= 1'b0;
      last_grant <= IW'(NREQ - 1);
      cur_id <= '0;
      timer <= '0;
    end else
      case (state)
        IDLE:
          if (found && !sq_busy) begin
            cur_id <= win;
            sq_rad <= req_rad[win*WIDTH +: WIDTH];
            state <= ISSUE;
          end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT:
          if (sq_valid) begin
            res_root <= sq_root;
            res_rem <= sq_rem;
            res_id <= cur_id;
            err <= 1'b0;
            state <= DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            res_root <= '0;
            res_rem <= '0;
            res_id <= cur_id;
            err <= 1'b1;
            state <= DONE;
          end else
            timer <= timer + 1'b1;
        default: begin
          last_grant <= res_id;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_adld_sqrt_arb.sv
// tb_adld_sqrt_arb: directed checks of arbitration, results, timeout, reset abort and busy hold-off
module tb_adld_sqrt_arb;
  logic clk = 0, rst = 1;
  logic [3:0] req = 0;
  logic [31:0] req_rad = 0;
  logic sq_busy = 0, stray = 0, core_dead = 0, cv = 0;
  logic [3:0] ack;
  logic [7:0] res_root, res_rem, sq_rad, last_rad;
  logic [7:0] sq_root = 0, sq_rem = 0, rad_l = 0;
  logic [1:0] res_id;
  logic err, sq_start, sq_valid;
  logic [2:0] cnt = 0;
  int total = 0, bad = 0, nstart = 0, cyc, base, seen;
  int er[4] = '{0, 1, 9, 15};
  int em[4] = '{0, 0, 0, 30};
  int eid[4] = '{0, 2, 0, 2};
  always #5 clk = ~clk;
  assign sq_valid = cv | stray;
  adld_sqrt_arb dut (
    .clk(clk), .rst(rst), .req(req), .req_rad(req_rad), .ack(ack),
    .res_root(res_root), .res_rem(res_rem), .res_id(res_id), .err(err),
    .sq_start(sq_start), .sq_rad(sq_rad), .sq_busy(sq_busy), .sq_valid(sq_valid),
    .sq_root(sq_root), .sq_rem(sq_rem)
  );
  function automatic int isqrt(int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction
  // core model: result strobe a few cycles after each start unless disabled
  always @(posedge clk) begin
    cv <= 1'b0;
    if (cnt != 0) begin
      cnt <= cnt - 1'b1;
      if (cnt == 1 && !core_dead) begin
        cv <= 1'b1;
        sq_root <= 8'(isqrt(int'(rad_l)));
        sq_rem <= 8'(int'(rad_l) - isqrt(int'(rad_l)) * isqrt(int'(rad_l)));
      end
    end
    if (sq_start) begin
      cnt <= 3'd3;
      rad_l <= sq_rad;
    end
  end
  always @(posedge clk)
    if (sq_start) begin
      nstart++;
      last_rad = sq_rad;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_ack();
    cyc = 0;
    while (ack == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("ack_seen", 32'(ack != 0), 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_start", sq_start, 0);
    chk("rst_rad", sq_rad, 0);
    chk("rst_root", res_root, 0);
    chk("rst_rem", res_rem, 0);
    chk("rst_id", res_id, 0);
    chk("rst_err", err, 0);
    rst = 0;
    nstart = 0;
    req_rad[7:0] = 8'd121;
    req = 4'b0001;
    wait_ack();
    chk("t1_lat", cyc, 6);
    chk("t1_ack", ack, 4'b0001);
    chk("t1_root", res_root, 11);
    chk("t1_rem", res_rem, 0);
    chk("t1_id", res_id, 0);
    chk("t1_err", err, 0);
    chk("t1_nstart", nstart, 1);
    chk("t1_rad", last_rad, 121);
    req = 0;
    @(negedge clk);
    chk("t1_pulse", ack, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    req_rad = {8'd255, 8'd81, 8'd1, 8'd0};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack();
      chk("t2_ack", ack, 32'(1 << i));
      chk("t2_root", res_root, er[i]);
      chk("t2_rem", res_rem, em[i]);
      req[i] = 1'b0;
      @(negedge clk);
    end
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_ack();
      chk("t3_id", res_id, eid[i]);
      chk("t3_ack", ack, 32'(1 << eid[i]));
      req[eid[i]] = 1'b0;
      if (i == 3) req = 0;
      @(negedge clk);
      if (i < 3) req[eid[i]] = 1'b1;
    end
    core_dead = 1;
    req = 4'b0010;
    wait_ack();
    chk("t4_lat", cyc, 66);
    chk("t4_ack", ack, 4'b0010);
    chk("t4_err", err, 1);
    chk("t4_root", res_root, 0);
    chk("t4_rem", res_rem, 0);
    chk("t4_id", res_id, 1);
    req = 0;
    core_dead = 0;
    @(negedge clk);
    req = 4'b1000;
    wait_ack();
    chk("t4b_ack", ack, 4'b1000);
    chk("t4b_root", res_root, 15);
    chk("t4b_rem", res_rem, 30);
    chk("t4b_err", err, 0);
    chk("t4b_id", res_id, 3);
    req = 0;
    @(negedge clk);
    core_dead = 1;
    req_rad[7:0] = 8'd121;
    req = 4'b0001;
    repeat (4) @(negedge clk);
    rst = 1;
    req = 0;
    @(negedge clk);
    rst = 0;
    chk("t5_ack", ack, 0);
    chk("t5_start", sq_start, 0);
    chk("t5_rad", sq_rad, 0);
    chk("t5_root", res_root, 0);
    chk("t5_rem", res_rem, 0);
    chk("t5_id", res_id, 0);
    chk("t5_err", err, 0);
    base = nstart;
    stray = 1;
    @(negedge clk);
    stray = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack != 0) seen++;
    end
    chk("t5_noack", seen, 0);
    chk("t5_nostart", nstart, base);
    chk("t5_root2", res_root, 0);
    core_dead = 0;
    sq_busy = 1;
    req = 4'b0100;
    base = nstart;
    repeat (5) @(negedge clk);
    chk("t6_hold", nstart, base);
    chk("t6_start0", sq_start, 0);
    sq_busy = 0;
    @(negedge clk);
    chk("t6_start1", sq_start, 1);
    chk("t6_rad", sq_rad, 81);
    wait_ack();
    chk("t6_ack", ack, 4'b0100);
    chk("t6_root", res_root, 9);
    chk("t6_rem", res_rem, 0);
    chk("t6_id", res_id, 2);
    req = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adld_sqrt_arb.md
ADLD_SQRT_ARB -- requirements
Module: adld_sqrt_arb

Interface
REQ-001 The block SHALL have the parameter NREQ, default 4, giving the number of requesters sharing one square-root core (2..8).
REQ-002 The block SHALL have the parameter WIDTH, default 8, giving the radicand, root and remainder width.
REQ-003 The block SHALL have the parameter TIMEOUT, default 64, giving the maximum cycles spent in WAIT before abort.
REQ-004 The block SHALL have the port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have the port req, input, NREQ bits: level request per requester, held until acked.
REQ-007 The block SHALL have the port req_rad, input, NREQ*WIDTH bits: radicand of requester i at [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have the port ack, output, NREQ bits: one-cycle completion pulse to the served requester.
REQ-009 The block SHALL have the port res_root, output, WIDTH bits: root of the last completed job.
REQ-010 The block SHALL have the port res_rem, output, WIDTH bits: remainder of the last completed job.
REQ-011 The block SHALL have the port res_id, output, $clog2(NREQ) bits: index of the last served requester.
REQ-012 The block SHALL have the port err, output, 1 bit: high with ack when the job timed out.
REQ-013 The block SHALL have the port sq_start, output, 1 bit: start pulse to the core.
REQ-014 The block SHALL have the port sq_rad, output, WIDTH bits: radicand to the core.
REQ-015 The block SHALL have the ports sq_busy and sq_valid, inputs, 1 bit each: core busy level and one-cycle result strobe.
REQ-016 The block SHALL have the ports sq_root and sq_rem, inputs, WIDTH bits each: core results, qualified by sq_valid.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE, with one state per cycle except WAIT.
REQ-018 In IDLE, if any req bit is high and sq_busy is low, the block SHALL select a winner round-robin, starting at last_grant+1 mod NREQ, latch its index and radicand, and go to ISSUE.
REQ-019 In IDLE with sq_busy high, the block SHALL stay in IDLE and issue nothing.
REQ-020 In ISSUE, sq_start SHALL be 1 for exactly one cycle, with sq_rad equal to the latched radicand, and the FSM SHALL then go to WAIT with the timer cleared.
REQ-021 sq_rad SHALL hold the latched radicand from ISSUE through the end of WAIT, so later req_rad changes have no effect.
REQ-022 In WAIT, sq_valid=1 SHALL capture sq_root and sq_rem and go to DONE with err cleared.
REQ-023 In WAIT, when the timer reaches TIMEOUT-1 without sq_valid, the block SHALL go to DONE with err=1 and res_root=res_rem=0.
REQ-024 If sq_valid and the timeout occur in the same cycle, sq_valid SHALL win.
REQ-025 In DONE, ack[res_id] SHALL be 1 for one cycle, with res_root, res_rem, res_id and err valid.
REQ-026 On leaving DONE, last_grant SHALL update to the served index, and the FSM SHALL return to IDLE.
REQ-027 res_root, res_rem, res_id and err SHALL hold their values until the next DONE.
REQ-028 A requester SHALL drop req on the edge where it samples ack=1, and a new job SHALL NOT start before the IDLE cycle following DONE.
REQ-029 sq_valid outside WAIT SHALL be ignored.
REQ-030 At most one ack bit SHALL be high in any cycle, and ack SHALL be 0 outside DONE.
REQ-031 Latency SHALL be core latency + 3 cycles, from the IDLE winner cycle to ack.

Reset
REQ-032 While rst=1, at any state including mid-WAIT, the block SHALL set the state to IDLE, ack=0, sq_start=0, sq_rad=0, res_root=0, res_rem=0, res_id=0, err=0 and last_grant=NREQ-1, so that requester 0 has first priority.
REQ-033 A job aborted by reset SHALL produce no ack, and a late sq_valid from that job SHALL be ignored.

Verification
REQ-034 Single requester: req[0] alone with rad=121 -> one sq_start with sq_rad=121, then ack[0] with root=11, rem=0, res_id=0, err=0.
REQ-035 Simultaneous requests: after reset, req=4'b1111 with rads 0, 1, 81, 255 -> acks in order 0, 1, 2, 3 with (root, rem) results (0,0), (1,0), (9,0), (15,30).
REQ-036 Fairness: req0 and req2 re-request immediately after each ack -> grants alternate 0, 2, 0, 2, and neither requester is starved.
REQ-037 Timeout: a core model that never asserts sq_valid -> ack with err=1, root=0, rem=0 after TIMEOUT cycles in WAIT, and the next request is served normally.
REQ-038 Reset in WAIT: rst pulsed mid-job, then sq_valid -> all outputs at reset values, no ack, and the stray sq_valid is ignored.
REQ-039 Busy core: sq_busy=1 in IDLE with a pending req -> no sq_start until sq_busy falls, then sq_start exactly one cycle later.
